// File: rtl/amdemod_seq.sv
// amdemod_seq: iterative vectoring-mode CORDIC that turns I/Q samples into magnitude and phase (integer degrees).
// Define AMDEMOD_GAIN_COMP_EN to scale the magnitude by ~0.609 so the CORDIC gain is cancelled.
module amdemod_seq #(
    parameter int W    = 8,
    parameter int ITER = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W:0]   x_in,
    input  logic signed [W:0]   y_in,
    output logic                busy,
    output logic                done,
    output logic        [W:0]   r_out,
    output logic signed [W:0]   phi_out
);

    typedef enum logic {ST_IDLE, ST_ITER} state_t;

    localparam logic signed [W+2:0] R_MAX = {3'b000, {W{1'b1}}};
    localparam logic signed [W:0]   DEG90 = (W+1)'(90);

    state_t                state_q, state_d;
    logic signed [W+2:0]   x_q, x_d, y_q, y_d;
    logic signed [W:0]     z_q, z_d;
    logic        [2:0]     count_q, count_d;
    logic                  done_q, done_d;
    logic        [W:0]     r_q, r_d;
    logic signed [W:0]     phi_q, phi_d;

    logic signed [W+2:0]   x_ext, y_ext, x_sh, y_sh, x_nx, y_nx, mag;
    logic signed [W:0]     z_nx;
    logic        [W:0]     r_sat;

    function automatic logic signed [W:0] atan_deg(input logic [2:0] i);
        case (i)
            3'd0:    atan_deg = (W+1)'(45);
            3'd1:    atan_deg = (W+1)'(26);
            3'd2:    atan_deg = (W+1)'(14);
            3'd3:    atan_deg = (W+1)'(7);
            3'd4:    atan_deg = (W+1)'(4);
            3'd5:    atan_deg = (W+1)'(2);
            default: atan_deg = (W+1)'(1);
        endcase
    endfunction

    // Shared micro-rotation datapath; the sign of y picks the rotation direction.
    always_comb begin
        x_ext = {{2{x_in[W]}}, x_in};
        y_ext = {{2{y_in[W]}}, y_in};
        x_sh  = x_q >>> count_q;
        y_sh  = y_q >>> count_q;
        if (!y_q[W+2]) begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + atan_deg(count_q);
        end else begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - atan_deg(count_q);
        end
`ifdef AMDEMOD_GAIN_COMP_EN
        mag = (x_nx >>> 1) + (x_nx >>> 3) - (x_nx >>> 6);
`else
        mag = x_nx;
`endif
        r_sat = (mag > R_MAX) ? R_MAX[W:0] : mag[W:0];
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        count_d = count_q;
        done_d  = 1'b0;
        r_d     = r_q;
        phi_d   = phi_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Pre-rotate left-half-plane vectors by +/-90 so the iterations converge.
                    if (!x_in[W]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!y_in[W]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = DEG90;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -DEG90;
                    end
                    count_d = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                x_d     = x_nx;
                y_d     = y_nx;
                z_d     = z_nx;
                count_d = count_q + 3'd1;
                if (count_q == 3'(ITER - 1)) begin
                    r_d     = r_sat;
                    phi_d   = z_nx;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            r_q     <= '0;
            phi_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            count_q <= count_d;
            done_q  <= done_d;
            r_q     <= r_d;
            phi_q   <= phi_d;
        end
    end

    assign busy    = (state_q == ST_ITER);
    assign done    = done_q;
    assign r_out   = r_q;
    assign phi_out = phi_q;

endmodule

// File: tb/tb_amdemod_seq.sv
// Scoreboard bench for amdemod_seq: randomized I/Q conversions checked against an integer CORDIC reference.
// Honours AMDEMOD_GAIN_COMP_EN the same way as the design.
module tb_amdemod_seq;

    localparam int W    = 8;
    localparam int ITER = 4;

    typedef struct {
        int r;
        int phi;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [W:0]   x_in;
    logic signed [W:0]   y_in;
    logic                busy;
    logic                done;
    logic        [W:0]   r_out;
    logic signed [W:0]   phi_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sbQueue[$];
    int   atanTab [8] = '{45, 26, 14, 7, 4, 2, 1, 1};
    logic donePrev = 1'b0;

    amdemod_seq #(.W(W), .ITER(ITER)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .busy    (busy),
        .done    (done),
        .r_out   (r_out),
        .phi_out (phi_out)
    );

    always #5 clk = ~clk;

    // Polar conversion by quadrant fold then ITER direction-seeking rotations on plain integers.
    function automatic exp_t model(input int xi, input int yi);
        exp_t e;
        int x, y, z, xn, mag;
        if (xi >= 0) begin
            x = xi;  y = yi;  z = 0;
        end else if (yi >= 0) begin
            x = yi;  y = -xi; z = 90;
        end else begin
            x = -yi; y = xi;  z = -90;
        end
        for (int i = 0; i < ITER; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atanTab[i];
            end else begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atanTab[i];
            end
            x = xn;
        end
`ifdef AMDEMOD_GAIN_COMP_EN
        mag = (x >>> 1) + (x >>> 3) - (x >>> 6);
`else
        mag = x;
`endif
        e.r = (mag > (2**W - 1)) ? (2**W - 1) : mag;
        z = z & ((1 << (W+1)) - 1);
        if (z >= (1 << W)) z = z - (1 << (W+1));
        e.phi = z;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int randSample();
        return int'($urandom_range(0, 2**(W+1) - 1)) - 2**W;
    endfunction

    // Issue one conversion; inputs are scrambled after acceptance, and start may stay high while busy.
    task automatic applyStimulus(input int xi, input int yi, input bit hold);
        @(negedge clk);
        start = 1'b1;
        x_in  = (W+1)'(xi);
        y_in  = (W+1)'(yi);
        @(posedge clk);
        sbQueue.push_back(model(xi, yi));
        #1;
        if (!hold) start = 1'b0;
        x_in = (W+1)'(randSample());
        y_in = (W+1)'(randSample());
        checkOutput("busy_after_accept", int'(busy), 1);
        for (int c = 1; c <= ITER; c++) begin
            @(posedge clk);
            #1;
            checkOutput("done_latency", int'(done), int'(c == ITER));
            checkOutput("busy_during", int'(busy), int'(c != ITER));
            x_in = (W+1)'(randSample());
            y_in = (W+1)'(randSample());
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            checkOutput("done_single_cycle", int'(donePrev), 0);
            checkOutput("sb_nonempty", int'(sbQueue.size() != 0), 1);
            if (sbQueue.size() != 0) begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("r_out", int'(r_out), e.r);
                checkOutput("phi_out", int'(phi_out), e.phi);
            end
        end
        donePrev <= done;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_r", int'(r_out), 0);
        checkOutput("reset_phi", int'(phi_out), 0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(100, 0, 1'b0);
        applyStimulus(0, 100, 1'b0);
        applyStimulus(-100, 0, 1'b0);
        applyStimulus(200, 200, 1'b0);
        applyStimulus(-256, -256, 1'b0);
        applyStimulus(255, -256, 1'b0);

        // start held high: back-to-back results, inputs changing while busy.
        for (int n = 0; n < 4; n++) applyStimulus(randSample(), randSample(), 1'b1);
        @(negedge clk);
        start = 1'b0;

        for (int n = 0; n < 40; n++) applyStimulus(randSample(), randSample(), n[0]);
        @(negedge clk);
        start = 1'b0;

        // Abort an in-flight conversion with reset.
        @(negedge clk);
        start = 1'b1;
        x_in  = (W+1)'(50);
        y_in  = (W+1)'(30);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_r", int'(r_out), 0);
        checkOutput("abort_phi", int'(phi_out), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < ITER + 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput("no_done_after_abort", int'(done), 0);
        end

        applyStimulus(-37, 121, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", sbQueue.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
